// File: rtl/csr_timer_unit_pkg.sv
// Shared CSR timer definitions.
// Holds the register-select encoding used by the CSR file to address the
// timer block, the bit positions inside TCFG/TICLR, and the masked-write
// helper shared by every writable register.
package cpuDefine;

    typedef enum logic [2:0] {
        SEL_TCFG  = 3'd0,
        SEL_TVAL  = 3'd1,
        SEL_TICLR = 3'd2,
        SEL_TID   = 3'd3,
        SEL_CNTL  = 3'd4,
        SEL_CNTH  = 3'd5
    } csr_tmr_sel_e;

    localparam int TCFG_EN_BIT   = 0;
    localparam int TCFG_PER_BIT  = 1;
    localparam int TICLR_CLR_BIT = 0;

    // Bits set in mask take the new data, all others keep the old value.
    function automatic logic [31:0] masked_merge(input logic [31:0] old_val,
                                                 input logic [31:0] data,
                                                 input logic [31:0] mask);
        return (old_val & ~mask) | (data & mask);
    endfunction

endpackage

// File: rtl/csr_timer_unit_chan.sv
// One countdown timer channel: TCFG, TVAL and the pending flag.
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   tick                 prescaled decrement strobe
//   cfg_we               TCFG write for this channel
//   clr_we               TICLR write for this channel
//   wr_data, wr_mask     raw write data and bit mask
//   tcfg, tval           current TCFG / TVAL, zero-extended to 32 bits
//   pending              registered interrupt pending
//   pending_next         next-state pending (for the registered OR at top)
module csr_timer_chan
    import cpuDefine::*;
#(
    parameter int TIMESIZE = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        tick,
    input  logic        cfg_we,
    input  logic        clr_we,
    input  logic [31:0] wr_data,
    input  logic [31:0] wr_mask,
    output logic [31:0] tcfg,
    output logic [31:0] tval,
    output logic        pending,
    output logic        pending_next
);

    logic [TIMESIZE-1:0] tcfg_r;
    logic [TIMESIZE-1:0] tval_r;
    logic                pending_r;
    logic [TIMESIZE-1:0] tcfg_n_s;
    logic [TIMESIZE-1:0] tval_n_s;
    logic [31:0]         merged_s;
    logic                set_s;
    logic                clr_s;
    logic                pending_n_s;

    // Next-state for config, count and pending; a TCFG write overrides any
    // timeout in the same cycle, and a timeout overrides a TICLR clear.
    always_comb begin
        merged_s = masked_merge(32'(tcfg_r), wr_data, wr_mask);
        tcfg_n_s = tcfg_r;
        tval_n_s = tval_r;
        set_s    = 1'b0;
        if (cfg_we) begin
            tcfg_n_s = merged_s[TIMESIZE-1:0];
            tval_n_s = {merged_s[TIMESIZE-1:2], 2'b00};
        end else if (tick && tcfg_r[TCFG_EN_BIT]) begin
            if (tval_r != {TIMESIZE{1'b0}}) begin
                tval_n_s = tval_r - TIMESIZE'(1);
            end else begin
                set_s = 1'b1;
                if (tcfg_r[TCFG_PER_BIT]) begin
                    tval_n_s = {tcfg_r[TIMESIZE-1:2], 2'b00};
                end else begin
                    tcfg_n_s[TCFG_EN_BIT] = 1'b0;
                end
            end
        end else begin
            tcfg_n_s = tcfg_r;
        end

        clr_s = clr_we & wr_mask[TICLR_CLR_BIT] & wr_data[TICLR_CLR_BIT];
        if (set_s) begin
            pending_n_s = 1'b1;
        end else if (clr_s) begin
            pending_n_s = 1'b0;
        end else begin
            pending_n_s = pending_r;
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tcfg_r    <= {TIMESIZE{1'b0}};
            tval_r    <= {TIMESIZE{1'b0}};
            pending_r <= 1'b0;
        end else begin
            tcfg_r    <= tcfg_n_s;
            tval_r    <= tval_n_s;
            pending_r <= pending_n_s;
        end
    end

    assign tcfg         = 32'(tcfg_r);
    assign tval         = 32'(tval_r);
    assign pending      = pending_r;
    assign pending_next = pending_n_s;

endmodule

// File: rtl/csr_timer_unit.sv
// Timer/counter CSR block: NUM_TIMERS countdown channels, TID, and a 64-bit
// stable counter with a CNTH shadow for coherent low-then-high reads.
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   wr_en/wr_sel/wr_chan        write strobe, register select, channel
//   wr_data/wr_mask             write data and bit mask
//   rd_en/rd_sel/rd_chan        read strobe (CNTL snapshot), select, channel
//   rd_data                     combinational read data
//   ti_pending/ti_any           registered interrupt pending per channel / OR
//   stable_cnt                  registered free-running 64-bit counter
module csr_timer_unit
    import cpuDefine::*;
#(
    parameter  int NUM_TIMERS = 2,
    parameter  int TIMESIZE   = 32,
    parameter  int PRESCALE   = 1,
    parameter  int CPU_ID     = 0,
    localparam int CH_W       = (NUM_TIMERS > 1) ? $clog2(NUM_TIMERS) : 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  wr_en,
    input  logic [2:0]            wr_sel,
    input  logic [CH_W-1:0]       wr_chan,
    input  logic [31:0]           wr_data,
    input  logic [31:0]           wr_mask,
    input  logic                  rd_en,
    input  logic [2:0]            rd_sel,
    input  logic [CH_W-1:0]       rd_chan,
    output logic [31:0]           rd_data,
    output logic [NUM_TIMERS-1:0] ti_pending,
    output logic                  ti_any,
    output logic [63:0]           stable_cnt
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    // Read arrays cover every encodable channel so out-of-range reads hit 0.
    localparam int RD_N = 2 ** CH_W;

    logic [PS_W-1:0]       ps_r;
    logic [63:0]           stable_cnt_r;
    logic [31:0]           cnth_r;
    logic [31:0]           tid_r;
    logic                  ti_any_r;
    logic                  tick_s;
    logic                  chan_ok_s;
    logic                  tid_we_s;
    logic [NUM_TIMERS-1:0] cfg_we_s;
    logic [NUM_TIMERS-1:0] clr_we_s;
    logic [NUM_TIMERS-1:0] pend_s;
    logic [NUM_TIMERS-1:0] pend_n_s;
    logic [31:0]           tcfg_rd_s [RD_N];
    logic [31:0]           tval_rd_s [RD_N];
    logic [31:0]           rd_data_s;

    assign tick_s    = (ps_r == PS_W'(PRESCALE - 1));
    assign chan_ok_s = ({1'b0, wr_chan} < (CH_W + 1)'(NUM_TIMERS));
    assign tid_we_s  = wr_en && (wr_sel == SEL_TID);

    for (genvar i = 0; i < RD_N; i++) begin : g_chan
        if (i < NUM_TIMERS) begin : g_live
            assign cfg_we_s[i] = wr_en && chan_ok_s && (wr_sel == SEL_TCFG)
                                 && (wr_chan == CH_W'(i));
            assign clr_we_s[i] = wr_en && chan_ok_s && (wr_sel == SEL_TICLR)
                                 && (wr_chan == CH_W'(i));

            csr_timer_chan #(
                .TIMESIZE(TIMESIZE)
            ) u_chan (
                .clk         (clk),
                .resetn      (resetn),
                .tick        (tick_s),
                .cfg_we      (cfg_we_s[i]),
                .clr_we      (clr_we_s[i]),
                .wr_data     (wr_data),
                .wr_mask     (wr_mask),
                .tcfg        (tcfg_rd_s[i]),
                .tval        (tval_rd_s[i]),
                .pending     (pend_s[i]),
                .pending_next(pend_n_s[i])
            );
        end else begin : g_empty
            assign tcfg_rd_s[i] = 32'd0;
            assign tval_rd_s[i] = 32'd0;
        end
    end

    // Prescaler, stable counter, CNTH shadow, TID and the pending summary.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ps_r         <= {PS_W{1'b0}};
            stable_cnt_r <= 64'd0;
            cnth_r       <= 32'd0;
            tid_r        <= 32'(CPU_ID);
            ti_any_r     <= 1'b0;
        end else begin
            ps_r         <= tick_s ? {PS_W{1'b0}} : ps_r + PS_W'(1);
            stable_cnt_r <= stable_cnt_r + 64'd1;
            // Capture the high word at the CNTL read so a later CNTH read
            // pairs with the low word even if a carry happened in between.
            if (rd_en && (rd_sel == SEL_CNTL)) begin
                cnth_r <= stable_cnt_r[63:32];
            end else begin
                cnth_r <= cnth_r;
            end
            if (tid_we_s) begin
                tid_r <= masked_merge(tid_r, wr_data, wr_mask);
            end else begin
                tid_r <= tid_r;
            end
            // Built from next-state pending so it changes on the same edge.
            ti_any_r <= |pend_n_s;
        end
    end

    // Read mux from current register state.
    always_comb begin
        rd_data_s = 32'd0;
        case (rd_sel)
            SEL_TCFG:  rd_data_s = tcfg_rd_s[rd_chan];
            SEL_TVAL:  rd_data_s = tval_rd_s[rd_chan];
            SEL_TICLR: rd_data_s = 32'd0;
            SEL_TID:   rd_data_s = tid_r;
            SEL_CNTL:  rd_data_s = stable_cnt_r[31:0];
            SEL_CNTH:  rd_data_s = cnth_r;
            default:   rd_data_s = 32'd0;
        endcase
    end

    assign rd_data    = rd_data_s;
    assign ti_pending = pend_s;
    assign ti_any     = ti_any_r;
    assign stable_cnt = stable_cnt_r;

endmodule

// File: tb/tb_csr_timer_unit.sv
// Directed bench for csr_timer_unit: dut1 (2 timers, PRESCALE=1, CPU_ID=0)
// covers one-shot, periodic, collisions, masked writes and CNTL/CNTH; dut2
// (3 timers, TIMESIZE=16, PRESCALE=4, CPU_ID=5) covers reset and prescaling.
module tb_csr_timer_unit;
    import cpuDefine::*;

    logic        clk;
    logic        resetn, resetn2;
    logic        wr_en, wr_en2;
    logic [2:0]  wr_sel;
    logic        wr_chan;
    logic [1:0]  wr_chan2;
    logic [31:0] wr_data, wr_mask;
    logic        rd_en;
    logic [2:0]  rd_sel;
    logic        rd_chan;
    logic [1:0]  rd_chan2;
    logic [31:0] rd_data, rd_data2;
    logic [1:0]  ti_pending;
    logic [2:0]  ti_pending2;
    logic        ti_any, ti_any2;
    logic [63:0] stable_cnt, stable_cnt2;

    int n_chk  = 0;
    int n_fail = 0;

    csr_timer_unit #(.NUM_TIMERS(2), .TIMESIZE(32), .PRESCALE(1), .CPU_ID(0)) dut1 (
        .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_chan(wr_chan), .wr_data(wr_data), .wr_mask(wr_mask),
        .rd_en(rd_en), .rd_sel(rd_sel), .rd_chan(rd_chan), .rd_data(rd_data),
        .ti_pending(ti_pending), .ti_any(ti_any), .stable_cnt(stable_cnt)
    );

    csr_timer_unit #(.NUM_TIMERS(3), .TIMESIZE(16), .PRESCALE(4), .CPU_ID(5)) dut2 (
        .clk(clk), .resetn(resetn2), .wr_en(wr_en2), .wr_sel(wr_sel),
        .wr_chan(wr_chan2), .wr_data(wr_data), .wr_mask(wr_mask),
        .rd_en(rd_en), .rd_sel(rd_sel), .rd_chan(rd_chan2), .rd_data(rd_data2),
        .ti_pending(ti_pending2), .ti_any(ti_any2), .stable_cnt(stable_cnt2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rd(input string tag, input bit t2, input logic [2:0] sel,
                          input int chan, input logic [31:0] exp);
        rd_sel = sel;
        if (t2) rd_chan2 = chan[1:0];
        else    rd_chan  = chan[0];
        #1;
        check(tag, t2 ? rd_data2 : rd_data, exp);
    endtask

    // Drive one write at the current negedge; returns at the next negedge.
    task automatic wr(input bit t2, input logic [2:0] sel, input int chan,
                      input logic [31:0] d, input logic [31:0] m);
        wr_sel  = sel;
        wr_data = d;
        wr_mask = m;
        if (t2) begin wr_en2 = 1'b1; wr_chan2 = chan[1:0]; end
        else    begin wr_en  = 1'b1; wr_chan  = chan[0];   end
        @(negedge clk);
        wr_en  = 1'b0;
        wr_en2 = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clk = 1'b0; resetn = 1'b0; resetn2 = 1'b0;
        wr_en = 1'b0; wr_en2 = 1'b0; wr_sel = 3'd0; wr_chan = 1'b0; wr_chan2 = 2'd0;
        wr_data = 32'd0; wr_mask = 32'd0; rd_en = 1'b0; rd_sel = 3'd0;
        rd_chan = 1'b0; rd_chan2 = 2'd0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_stable", stable_cnt, 64'd0);
        check("rst_pend", ti_pending, 2'b00);
        check("rst_any", ti_any, 1'b0);
        chk_rd("rst_tcfg0", 1'b0, SEL_TCFG, 0, 32'd0);
        chk_rd("rst_tid", 1'b0, SEL_TID, 0, 32'd0);
        chk_rd("rst_tid2", 1'b1, SEL_TID, 0, 32'd5);
        @(negedge clk);
        resetn = 1'b1; resetn2 = 1'b1;
        @(negedge clk);
        check("stable_first", stable_cnt, 64'd1);

        // TID masked write; TVAL write ignored
        wr(1'b0, SEL_TID, 0, 32'hA5A5_1234, 32'hFFFF_0000);
        chk_rd("tid_masked", 1'b0, SEL_TID, 0, 32'hA5A5_0000);
        wr(1'b0, SEL_TVAL, 0, 32'h0000_00FF, 32'hFFFF_FFFF);
        chk_rd("tval_ro", 1'b0, SEL_TVAL, 0, 32'd0);
        chk_rd("tval_ro_tcfg", 1'b0, SEL_TCFG, 0, 32'd0);
        chk_rd("ticlr_reads0", 1'b0, SEL_TICLR, 0, 32'd0);

        // 1. One-shot ch0, InitVal=4, En
        wr(1'b0, SEL_TCFG, 0, 32'h11, 32'hFFFF_FFFF);
        chk_rd("t1_tval_load", 1'b0, SEL_TVAL, 0, 32'd16);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            chk_rd("t1_tval", 1'b0, SEL_TVAL, 0, 32'(16 - k));
        end
        check("t1_pend_early", ti_pending, 2'b00);
        @(negedge clk);
        check("t1_pend", ti_pending, 2'b01);
        check("t1_any", ti_any, 1'b1);
        chk_rd("t1_en_clr", 1'b0, SEL_TCFG, 0, 32'h10);
        repeat (3) @(negedge clk);
        chk_rd("t1_tval_hold", 1'b0, SEL_TVAL, 0, 32'd0);

        // 2. Periodic ch1, InitVal=2, Per, En: period 9
        wr(1'b0, SEL_TICLR, 0, 32'h1, 32'hFFFF_FFFF);
        check("t2_clr0", ti_pending, 2'b00);
        check("t2_clr0_any", ti_any, 1'b0);
        wr(1'b0, SEL_TCFG, 1, 32'h0B, 32'hFFFF_FFFF);
        chk_rd("t2_load", 1'b0, SEL_TVAL, 1, 32'd8);
        repeat (8) @(negedge clk);
        chk_rd("t2_tval0", 1'b0, SEL_TVAL, 1, 32'd0);
        check("t2_pend_early", ti_pending, 2'b00);
        @(negedge clk);
        check("t2_pend", ti_pending, 2'b10);
        check("t2_any", ti_any, 1'b1);
        chk_rd("t2_reload", 1'b0, SEL_TVAL, 1, 32'd8);
        wr(1'b0, SEL_TICLR, 1, 32'h1, 32'hFFFF_FFFF);
        check("t2_clr", ti_pending, 2'b00);
        check("t2_clr_any", ti_any, 1'b0);
        chk_rd("t2_tval7", 1'b0, SEL_TVAL, 1, 32'd7);
        repeat (8) @(negedge clk);
        check("t2_pend_again", ti_pending, 2'b10);

        // 3. TICLR with bit0 masked off, then clear colliding with a timeout
        wr(1'b0, SEL_TICLR, 1, 32'h1, 32'hFFFF_FFFE);
        check("t3_masked_clr", ti_pending, 2'b10);
        wr(1'b0, SEL_TICLR, 1, 32'h1, 32'hFFFF_FFFF);
        check("t3_clr", ti_pending, 2'b00);
        repeat (6) @(negedge clk);
        chk_rd("t3_tval0", 1'b0, SEL_TVAL, 1, 32'd0);
        check("t3_pend_pre", ti_pending, 2'b00);
        wr(1'b0, SEL_TICLR, 1, 32'h1, 32'hFFFF_FFFF);
        check("t3_collide_pend", ti_pending, 2'b10);
        check("t3_collide_any", ti_any, 1'b1);
        chk_rd("t2_ch0_tval", 1'b0, SEL_TVAL, 0, 32'd0);
        chk_rd("t2_ch0_tcfg", 1'b0, SEL_TCFG, 0, 32'h10);

        // 4. Masked TCFG write landing on a timeout cycle
        wr(1'b0, SEL_TICLR, 1, 32'h1, 32'hFFFF_FFFF);
        check("t4_clr", ti_pending, 2'b00);
        repeat (7) @(negedge clk);
        chk_rd("t4_tval0", 1'b0, SEL_TVAL, 1, 32'd0);
        wr(1'b0, SEL_TCFG, 1, 32'h0, 32'h1);
        chk_rd("t4_tcfg", 1'b0, SEL_TCFG, 1, 32'h0A);
        chk_rd("t4_reload", 1'b0, SEL_TVAL, 1, 32'd8);
        check("t4_no_event", ti_pending, 2'b00);
        check("t4_no_any", ti_any, 1'b0);
        repeat (20) @(negedge clk);
        check("t4_quiet", ti_pending, 2'b00);
        chk_rd("t4_frozen", 1'b0, SEL_TVAL, 1, 32'd8);

        // 5. CNTL/CNTH coherence across a low-word carry
        force dut1.stable_cnt_r = 64'h0000_0001_FFFF_FFFF;
        rd_en  = 1'b1;
        rd_sel = SEL_CNTL;
        #1;
        check("t5_cntl", rd_data, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        release dut1.stable_cnt_r;
        rd_en = 1'b0;
        repeat (3) @(negedge clk);
        chk_rd("t5_cnth", 1'b0, SEL_CNTH, 0, 32'h1);
        check("t5_live_hi", stable_cnt[63:32], 32'h2);

        // 6. PRESCALE=4, reset pulse mid-countdown, out-of-range channel
        wr(1'b1, SEL_TCFG, 0, 32'h11, 32'hFFFF_FFFF);
        repeat (6) @(negedge clk);
        chk_rd("t6_pre_tcfg", 1'b1, SEL_TCFG, 0, 32'h11);
        resetn2 = 1'b0;
        #1;
        check("t6_rst_pend", ti_pending2, 3'b000);
        check("t6_rst_any", ti_any2, 1'b0);
        check("t6_rst_stable", stable_cnt2, 64'd0);
        chk_rd("t6_rst_tval", 1'b1, SEL_TVAL, 0, 32'd0);
        chk_rd("t6_rst_tcfg", 1'b1, SEL_TCFG, 0, 32'd0);
        chk_rd("t6_rst_tid", 1'b1, SEL_TID, 0, 32'd5);
        @(negedge clk);
        resetn2 = 1'b1;
        wr(1'b1, SEL_TCFG, 0, 32'h11, 32'hFFFF_FFFF);
        chk_rd("t6_load", 1'b1, SEL_TVAL, 0, 32'd16);
        check("t6_stable", stable_cnt2, 64'd1);
        for (int k = 2; k <= 8; k++) begin
            @(negedge clk);
            chk_rd("t6_prescale", 1'b1, SEL_TVAL, 0, 32'(16 - (k / 4)));
        end
        wr(1'b1, SEL_TCFG, 3, 32'h0B, 32'hFFFF_FFFF);
        chk_rd("t6_oor_ch0_tcfg", 1'b1, SEL_TCFG, 0, 32'h11);
        chk_rd("t6_oor_ch0_tval", 1'b1, SEL_TVAL, 0, 32'd14);
        chk_rd("t6_oor_ch2", 1'b1, SEL_TCFG, 2, 32'd0);
        chk_rd("t6_oor_rd", 1'b1, SEL_TCFG, 3, 32'd0);
        check("t6_oor_pend", ti_pending2, 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
